// File: rtl/neopix_frame_sched.sv
// neopix_frame_sched
// Assembles SPI bytes into 24-bit {G,R,B} pixel writes and schedules a full
// WS2812 refresh (every pixel, then a latch low-time) after each frame that
// wrote at least one pixel.
//
// Handshakes: rx_valid, rx_frame_end, px_done, wr_en, px_start and frame_done
// are single-cycle strobes with no back-pressure. A strobe is consumed on the
// rising edge where it is high. px_start asks the serializer for px_addr.
// The serializer answers with exactly one px_done, at least one cycle later.
// The buffer write port is always ready, so wr_en is never held off.
//
// dbg_state exposes the refresh FSM: 0 IDLE, 1 REQ, 2 WAIT, 3 LATCH.
module neopix_frame_sched #(
   parameter int  NUM_LEDS     = 4,
   parameter int  LATCH_CYCLES = 2750,
   localparam int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic          CLOCK_50,
   input  logic          RESET,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   input  logic          rx_frame_end,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [23:0]   wr_data,
   output logic          px_start,
   output logic [AW-1:0] px_addr,
   input  logic          px_done,
   output logic          latch,
   output logic          frame_done,
   output logic          overflow,
   output logic [1:0]    dbg_state
);

   // Pixel counter must reach NUM_LEDS itself, hence one extra bit.
   localparam int PW = AW + 1;
   localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_LATCH = 2'd3
   } state_t;

   state_t        r_state;
   logic [1:0]    r_byte_cnt;
   logic [PW-1:0] r_px_cnt;
   logic [23:0]   r_asm;
   logic          r_wr_en;
   logic [AW-1:0] r_wr_addr;
   logic          r_overflow;
   logic          r_pending;
   logic          r_px_start;
   logic [AW-1:0] r_px_addr;
   logic          r_latch;
   logic [LW-1:0] r_lat_cnt;
   logic          r_frame_done;

   logic          w_accept;
   logic          w_third;
   logic          w_pend_set;
   logic          w_pend_take;

   // A byte is kept only while the strip still has room in this frame.
   assign w_accept    = rx_valid && (r_px_cnt < PW'(NUM_LEDS));
   assign w_third     = w_accept && (r_byte_cnt == 2'd2);
   // A pixel completing on the frame_end cycle still counts as written.
   assign w_pend_set  = rx_frame_end && ((r_px_cnt != '0) || w_third);
   assign w_pend_take = (r_state == S_IDLE) && r_pending;

   // Byte assembly, buffer writes, overflow flag and the pending request.
   // The assembly register doubles as wr_data: after the third shift it
   // holds the finished word for the wr_en cycle.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_byte_cnt <= '0;
         r_px_cnt   <= '0;
         r_asm      <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_overflow <= 1'b0;
         r_pending  <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_accept) begin
            r_asm <= {r_asm[15:0], rx_data};
            if (w_third) begin
               r_byte_cnt <= 2'd0;
               r_px_cnt   <= r_px_cnt + PW'(1);
               r_wr_en    <= 1'b1;
               r_wr_addr  <= r_px_cnt[AW-1:0];
            end else begin
               r_byte_cnt <= r_byte_cnt + 2'd1;
            end
         end
         if (rx_valid && !w_accept) begin
            r_overflow <= 1'b1;
         end
         // Frame end wins over the counter updates above; the write of a
         // coincident third byte is already registered.
         if (rx_frame_end) begin
            r_byte_cnt <= 2'd0;
            r_px_cnt   <= '0;
         end
         // A new request beats consumption so a frame ending on the same
         // cycle the FSM starts is not lost.
         if (w_pend_set) begin
            r_pending <= 1'b1;
         end else if (w_pend_take) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Refresh FSM: request each pixel in turn, then time the latch low-time.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_state      <= S_IDLE;
         r_px_start   <= 1'b0;
         r_px_addr    <= '0;
         r_latch      <= 1'b0;
         r_lat_cnt    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_px_start   <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_pending) begin
                  r_px_addr  <= '0;
                  r_px_start <= 1'b1;
                  r_state    <= S_REQ;
               end
            end
            S_REQ: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (px_done) begin
                  if (r_px_addr == AW'(NUM_LEDS - 1)) begin
                     r_lat_cnt <= '0;
                     r_latch   <= 1'b1;
                     r_state   <= S_LATCH;
                  end else begin
                     r_px_addr  <= r_px_addr + AW'(1);
                     r_px_start <= 1'b1;
                     r_state    <= S_REQ;
                  end
               end
            end
            S_LATCH: begin
               if (r_lat_cnt == LW'(LATCH_CYCLES - 1)) begin
                  r_latch      <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_state      <= S_IDLE;
               end else begin
                  r_lat_cnt <= r_lat_cnt + LW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_asm;
   assign px_start   = r_px_start;
   assign px_addr    = r_px_addr;
   assign latch      = r_latch;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;
   assign dbg_state  = r_state;

endmodule
